// File: rtl/clock_divider_prog.sv
// Runtime-programmable 50%-duty clock divider. It produces a registered square wave and
// registered single-cycle tick/rise strobes, which downstream logic uses as clock-enables.
module clock_divider_prog #(
  parameter int WIDTH        = 27,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] half_period,
  output logic             clk_out,
  output logic             tick,
  output logic             rise,
  output logic [WIDTH-1:0] half_cur
);

  localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             rise_q, rise_d;
  logic             term;

  // half_q is never 0, so the subtraction cannot wrap; counter tops out at 2^WIDTH-2.
  assign term = (cnt_q == half_q - WIDTH'(1));

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    out_d  = out_q;
    tick_d = 1'b0;
    rise_d = 1'b0;
    if (load) begin
      half_d = (half_period == '0) ? WIDTH'(1) : half_period;
      cnt_d  = '0;
      out_d  = 1'b0;
    end else if (en) begin
      if (term) begin
        cnt_d  = '0;
        out_d  = ~out_q;
        tick_d = 1'b1;
        rise_d = ~out_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= DEF_HALF;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      rise_q <= rise_d;
    end
  end

  assign clk_out  = out_q;
  assign tick     = tick_q;
  assign rise     = rise_q;
  assign half_cur = half_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog. It runs directed steps followed by random steps. The reference
// model tracks the enabled cycles since the last restart and derives the outputs arithmetically.
module tb_clock_divider_prog;

  localparam int W   = 8;
  localparam int DEF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] half_period = '0;
  logic         clk_out, tick, rise;
  logic [W-1:0] half_cur;

  int tests  = 0;
  int failed = 0;

  longint n    = 0;
  int     half = DEF;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .half_period(half_period),
    .clk_out(clk_out), .tick(tick), .rise(rise), .half_cur(half_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive the inputs, advance the model, then compare just after the edge.
  task automatic step(input logic r, input logic l, input logic e, input int hp);
    bit tk;
    int ec;
    rst = r; load = l; en = e; half_period = W'(hp);
    @(posedge clk);
    tk = 1'b0;
    if (r) begin
      n = 0; half = DEF;
    end else if (l) begin
      n = 0; half = (hp == 0) ? 1 : hp;
    end else if (e) begin
      n++;
      tk = (n % half) == 0;
    end
    ec = int'((n / half) % 2);
    #1;
    check("clk_out",  32'(clk_out),  ec);
    check("tick",     32'(tick),     32'(tk));
    check("rise",     32'(rise),     (tk && ec == 1) ? 1 : 0);
    check("half_cur", 32'(half_cur), half);
  endtask

  task automatic run(input int cycles, input logic e);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, e, 0);
  endtask

  initial begin
    // Reset default, then free-run with en=1: toggles at 4, 8, 12.
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    run(13, 1'b1);
    // Mid-phase load of 3.
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3);
    run(7, 1'b1);
    // Clamp to 1: toggles on every cycle.
    step(1'b0, 1'b1, 1'b1, 0);
    run(6, 1'b1);
    // Enable gating at counter=2.
    step(1'b0, 1'b1, 1'b0, 4);
    run(2, 1'b1);
    run(5, 1'b0);
    run(4, 1'b1);
    // Load coincident with terminal count.
    step(1'b0, 1'b1, 1'b1, 4);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5);
    run(6, 1'b1);
    // Reset beats load.
    step(1'b1, 1'b1, 1'b1, 7);
    run(5, 1'b1);
    // Maximum divisor, then reset mid-phase.
    step(1'b0, 1'b1, 1'b1, (1 << W) - 1);
    run(2 * ((1 << W) - 1) + 20, 1'b1);
    step(1'b1, 1'b0, 1'b1, 0);
    run(3, 1'b1);
    // Random mix.
    for (int i = 0; i < 3000; i++) begin
      automatic int  rr = $urandom_range(0, 199);
      automatic int  lr = $urandom_range(0, 99);
      automatic int  hp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                                       : int'($urandom_range(0, 9));
      automatic logic e = ($urandom_range(0, 4) != 0);
      step(rr == 0, lr < 3, e, hp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
